rifl_frame_checker: RTL and testbench
=====================================

Name: rifl_frame_checker

Overview:
- Receive-side frame validator for the RIFL link, placed after the descrambler.
- Checks each frame's CRC, which is keyed with the expected frame ID, over one or more beats.
- Tracks expected ID against a high-water mark, drops replayed duplicates, raises a rollback retransmit request on CRC failure, and keeps saturating statistics counters.
- Extends the single-mode check with: configurable rollback depth, a retransmit request/ID, abort handling, duplicate classification and counters.

Parameters:
- FRAME_WIDTH, 256: frame size in bits; must be an integer multiple of DWIDTH.
- DWIDTH, 64: beat width; BEATS = FRAME_WIDTH/DWIDTH, with BEATS >= 1.
- CRC_WIDTH, 12: CRC field width, located in the LSBs of the last beat.
- CRC_POLY, 12'h02F: generator polynomial in normal representation, implicit x^CRC_WIDTH.
- FRAME_ID_WIDTH, 8: frame ID width; must be <= CRC_WIDTH.
- ROLLBACK, 16: frames rewound on CRC error; must be < 2^FRAME_ID_WIDTH.
- STAT_WIDTH, 16: width of each statistics counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- rx_up, input, 1: link up; beats are qualified by it.
- sof, input, 1: marks the first beat of a frame; ignored when BEATS==1.
- data_in, input, DWIDTH: beat data, MSB first.
- stats_clr, input, 1: synchronous clear of all counters.
- frame_good, output, 1: pulse; new, in-order data frame accepted.
- ctrl_good, output, 1: pulse; control frame with good CRC.
- frame_dup, output, 1: pulse; good replayed data frame, dropped.
- rx_error, output, 1: level; set on a CRC failure, held until replay catches up.
- retrans_req, output, 1: pulse on a CRC failure.
- retrans_id, output, FRAME_ID_WIDTH: ID to resend from; valid while retrans_req is high.
- exp_id, output, FRAME_ID_WIDTH: current expected frame ID.
- good_cnt, output, STAT_WIDTH: count of frame_good events.
- crc_err_cnt, output, STAT_WIDTH: count of CRC failures.
- dup_cnt, output, STAT_WIDTH: count of frame_dup events.
- abort_cnt, output, STAT_WIDTH: count of aborted frames.

Behaviour:
- Reset values:
  - All outputs 0.
  - exp_id = 0, hwm (internal high-water mark) = 0.
  - Beat counter idle.
  - CRC accumulator 0.
- Beat counter:
  - A frame starts on sof & rx_up while idle or mid-frame.
  - The counter then advances one per cycle; the tail is beat BEATS-1.
  - When BEATS==1, every rx_up cycle is a complete frame.
- Abort conditions (mid-frame only):
  - sof & rx_up arriving mid-frame restarts the frame: abort_cnt++, no ID/error update.
  - rx_up low mid-frame returns the counter to idle: abort_cnt++, no ID/error update.
- Header:
  - data_in[DWIDTH-1 -: 2] of the first beat is latched.
  - 2'b01 means data frame; any other value means control frame.
- CRC:
  - Bit-serial, left-shifting LFSR; init 0 at each frame start.
  - Processes DWIDTH bits per cycle, MSB first.
  - Feedback = crc[MSB] ^ data bit; the feedback is XORed into each bit j where CRC_POLY[j] is set.
  - The last CRC_WIDTH bits of the tail beat are replaced by 0 in the computation.
  - crc_ok = (computed ^ data_in[CRC_WIDTH-1:0] ^ zero-extended exp_id) == 0.
- Tail decision, evaluated in priority order with outputs registered on the following cycle:
  1. Not crc_ok:
     - exp_id <= hwm - ROLLBACK (mod 2^FRAME_ID_WIDTH); hwm unchanged.
     - rx_error <= 1; retrans_req = 1 with retrans_id = hwm - ROLLBACK; crc_err_cnt++.
  2. crc_ok, data, exp_id == hwm: frame_good = 1; exp_id++; hwm++; good_cnt++.
  3. crc_ok, data, exp_id != hwm: frame_dup = 1; exp_id++; dup_cnt++.
  4. crc_ok, control: ctrl_good = 1; IDs unchanged.
- rx_error clear:
  - Cleared on a crc_ok tail (data or control) when pre-update exp_id+1 == hwm or exp_id == hwm.
  - A CRC failure in the same tail always wins over the clear.
- Latency: pulses and counters update exactly 1 cycle after the tail beat and last 1 cycle.
- Arithmetic:
  - IDs wrap modulo 2^FRAME_ID_WIDTH, including hwm - ROLLBACK below 0.
  - Counters saturate at all-ones.
- stats_clr:
  - Zeroes all counters.
  - A same-cycle increment is lost; the counter reads 0.
- rst mid-frame discards the partial frame, with no counter update.

Test Plan:
- Default parameters; 4-beat data frames with IDs 0..3 and correct CRCs -> frame_good pulses 1 cycle after each tail; exp_id=4; good_cnt=4; rx_error=0.
- After 20 good frames (hwm=20), corrupt one CRC bit -> retrans_req=1, retrans_id=4, rx_error=1, exp_id=4, crc_err_cnt=1.
  - Replay IDs 4..19: 16 frame_dup pulses, no frame_good; rx_error clears after ID 19; ID 20 gives frame_good.
- Error with hwm=5, ROLLBACK=16 -> retrans_id=245 (wrap).
  - ID 255 -> 0 rollover accepted normally.
- Control frame (header 2'b10) with good CRC -> ctrl_good pulse; exp_id unchanged; counters unchanged.
- sof at beat 2 of a frame, then a complete good frame -> abort_cnt=1; the second frame gets frame_good.
  - rx_up dropped at beat 1 -> abort_cnt=2.
- BEATS==1 (FRAME_WIDTH=DWIDTH=64): back-to-back good frames every cycle -> continuous frame_good.
  - stats_clr in the same cycle as a good frame -> good_cnt=0.
  - STAT_WIDTH=2 saturates at 3.

Source files
------------

// File: rtl/rifl_frame_checker_if.sv
// Receive-side bus of the RIFL frame checker: qualified beats in, frame verdicts,
// retransmit request and statistics out.
interface rifl_frame_checker_if #(
    parameter int DWIDTH         = 64,
    parameter int FRAME_ID_WIDTH = 8,
    parameter int STAT_WIDTH     = 16
);
    logic                      rx_up;
    logic                      sof;
    logic [DWIDTH-1:0]         data_in;
    logic                      stats_clr;
    logic                      frame_good;
    logic                      ctrl_good;
    logic                      frame_dup;
    logic                      rx_error;
    logic                      retrans_req;
    logic [FRAME_ID_WIDTH-1:0] retrans_id;
    logic [FRAME_ID_WIDTH-1:0] exp_id;
    logic [STAT_WIDTH-1:0]     good_cnt;
    logic [STAT_WIDTH-1:0]     crc_err_cnt;
    logic [STAT_WIDTH-1:0]     dup_cnt;
    logic [STAT_WIDTH-1:0]     abort_cnt;

    modport master (
        output rx_up, sof, data_in, stats_clr,
        input  frame_good, ctrl_good, frame_dup, rx_error, retrans_req, retrans_id,
               exp_id, good_cnt, crc_err_cnt, dup_cnt, abort_cnt
    );

    modport slave (
        input  rx_up, sof, data_in, stats_clr,
        output frame_good, ctrl_good, frame_dup, rx_error, retrans_req, retrans_id,
               exp_id, good_cnt, crc_err_cnt, dup_cnt, abort_cnt
    );
endinterface

// File: rtl/rifl_frame_checker.sv
// RIFL receive frame validator: ID-keyed multi-beat CRC check, replay/duplicate
// tracking against a high-water mark, rollback retransmit request and statistics.
module rifl_frame_checker #(
    parameter int                   FRAME_WIDTH    = 256,
    parameter int                   DWIDTH         = 64,
    parameter int                   CRC_WIDTH      = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02F,
    parameter int                   FRAME_ID_WIDTH = 8,
    parameter int                   ROLLBACK       = 16,
    parameter int                   STAT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    rifl_frame_checker_if.slave bus
);
    localparam int BEATS = FRAME_WIDTH / DWIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                    state_reg, state_next;
    logic [BW-1:0]             beat_reg, beat_next;
    logic [1:0]                hdr_reg;
    logic [CRC_WIDTH-1:0]      crc_reg, crc_calc;
    logic [FRAME_ID_WIDTH-1:0] exp_id_reg, exp_id_next, hwm_reg, hwm_next;
    logic [FRAME_ID_WIDTH-1:0] exp_inc, rollback_id, retrans_id_reg;
    logic                      rx_error_reg, rx_error_next;
    logic                      frame_good_reg, ctrl_good_reg, frame_dup_reg, retrans_req_reg;
    logic                      first_beat, tail_beat, abort;
    logic                      crc_ok, is_data;
    logic                      tail_ok, tail_fail, tail_good, tail_dup, tail_ctrl;
    logic [DWIDTH-1:0]         beat_data;
    logic [3:0]                cnt_inc;
    logic [3:0][STAT_WIDTH-1:0] cnt_reg;

    // Bit-serial LFSR applied to a whole beat, MSB first.
    function automatic logic [CRC_WIDTH-1:0] crc_beat(input logic [CRC_WIDTH-1:0] c_in,
                                                      input logic [DWIDTH-1:0]    d);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = c_in;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ d[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        first_beat = 1'b0;
        tail_beat  = 1'b0;
        abort      = 1'b0;
        if (BEATS == 1) begin
            state_next = S_IDLE;
            first_beat = bus.rx_up;
            tail_beat  = bus.rx_up;
        end else if (!bus.rx_up) begin
            abort      = (state_reg == S_BUSY);
            state_next = S_IDLE;
            beat_next  = '0;
        end else if (bus.sof) begin
            abort      = (state_reg == S_BUSY);
            first_beat = 1'b1;
            state_next = S_BUSY;
            beat_next  = BW'(1);
        end else if (state_reg == S_BUSY) begin
            if (beat_reg == BW'(BEATS - 1)) begin
                tail_beat  = 1'b1;
                state_next = S_IDLE;
                beat_next  = '0;
            end else begin
                beat_next = beat_reg + 1'b1;
            end
        end
    end

    // The CRC field itself is fed to the LFSR as zeros.
    assign beat_data   = tail_beat ? {bus.data_in[DWIDTH-1:CRC_WIDTH], {CRC_WIDTH{1'b0}}}
                                   : bus.data_in;
    assign crc_calc    = crc_beat(first_beat ? '0 : crc_reg, beat_data);
    assign crc_ok      = (crc_calc ^ bus.data_in[CRC_WIDTH-1:0] ^ CRC_WIDTH'(exp_id_reg)) == '0;
    assign is_data     = (first_beat ? bus.data_in[DWIDTH-1 -: 2] : hdr_reg) == 2'b01;
    assign exp_inc     = exp_id_reg + 1'b1;
    assign rollback_id = hwm_reg - FRAME_ID_WIDTH'(ROLLBACK);

    assign tail_ok   = tail_beat & crc_ok;
    assign tail_fail = tail_beat & ~crc_ok;
    assign tail_good = tail_ok & is_data & (exp_id_reg == hwm_reg);
    assign tail_dup  = tail_ok & is_data & (exp_id_reg != hwm_reg);
    assign tail_ctrl = tail_ok & ~is_data;

    always_comb begin
        exp_id_next   = exp_id_reg;
        hwm_next      = hwm_reg;
        rx_error_next = rx_error_reg;
        if (tail_fail) begin
            exp_id_next   = rollback_id;
            rx_error_next = 1'b1;
        end else if (tail_ok) begin
            // Replay has caught up with (or is one short of) the high-water mark.
            if (exp_inc == hwm_reg || exp_id_reg == hwm_reg)
                rx_error_next = 1'b0;
            if (tail_good) begin
                exp_id_next = exp_inc;
                hwm_next    = hwm_reg + 1'b1;
            end else if (tail_dup) begin
                exp_id_next = exp_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            beat_reg        <= '0;
            hdr_reg         <= '0;
            crc_reg         <= '0;
            exp_id_reg      <= '0;
            hwm_reg         <= '0;
            rx_error_reg    <= 1'b0;
            frame_good_reg  <= 1'b0;
            ctrl_good_reg   <= 1'b0;
            frame_dup_reg   <= 1'b0;
            retrans_req_reg <= 1'b0;
            retrans_id_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            beat_reg        <= beat_next;
            if (first_beat)
                hdr_reg <= bus.data_in[DWIDTH-1 -: 2];
            if (bus.rx_up)
                crc_reg <= crc_calc;
            exp_id_reg      <= exp_id_next;
            hwm_reg         <= hwm_next;
            rx_error_reg    <= rx_error_next;
            frame_good_reg  <= tail_good;
            ctrl_good_reg   <= tail_ctrl;
            frame_dup_reg   <= tail_dup;
            retrans_req_reg <= tail_fail;
            if (tail_fail)
                retrans_id_reg <= rollback_id;
        end
    end

    assign cnt_inc = {abort, tail_dup, tail_fail, tail_good};

    // Counter order: good, crc error, duplicate, abort. Clear beats a same-cycle increment.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || bus.stats_clr)
                cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && cnt_reg[gi] != '1)
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
    end

    assign bus.frame_good  = frame_good_reg;
    assign bus.ctrl_good   = ctrl_good_reg;
    assign bus.frame_dup   = frame_dup_reg;
    assign bus.rx_error    = rx_error_reg;
    assign bus.retrans_req = retrans_req_reg;
    assign bus.retrans_id  = retrans_id_reg;
    assign bus.exp_id      = exp_id_reg;
    assign bus.good_cnt    = cnt_reg[0];
    assign bus.crc_err_cnt = cnt_reg[1];
    assign bus.dup_cnt     = cnt_reg[2];
    assign bus.abort_cnt   = cnt_reg[3];
endmodule

// File: tb/tb_rifl_frame_checker.sv
// Randomized scoreboard bench for rifl_frame_checker: a 4-beat instance checked against a
// rule-level model, plus a single-beat instance with 2-bit counters.
module tb_rifl_frame_checker;
    localparam int RB = 16;

    typedef struct packed {
        logic        fg;
        logic        cg;
        logic        dup;
        logic        rr;
        logic [7:0]  rid;
        logic        err;
        logic [7:0]  exp;
        logic [15:0] good;
        logic [15:0] crcc;
        logic [15:0] dupc;
        logic [15:0] abrt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rifl_frame_checker_if #(.DWIDTH(64), .FRAME_ID_WIDTH(8), .STAT_WIDTH(16)) bus ();
    rifl_frame_checker_if #(.DWIDTH(64), .FRAME_ID_WIDTH(8), .STAT_WIDTH(2))  bus1 ();

    rifl_frame_checker dut (.clk(clk), .rst(rst), .bus(bus));
    rifl_frame_checker #(.FRAME_WIDTH(64), .DWIDTH(64), .STAT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    obs_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  m_exp, m_hwm;
    logic        m_err;
    logic [15:0] m_good, m_crc, m_dup, m_abort;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Polynomial long division of (frame with zeroed CRC field) * x^12 by x^12 + 0x02F.
    function automatic logic [11:0] crc_ref(input logic [255:0] f, input int nbits);
        logic        msg [0:267];
        logic [12:0] gen;
        logic [11:0] r;
        gen = {1'b1, 12'h02F};
        for (int i = 0; i < nbits + 12; i++)
            msg[i] = (i < nbits - 12) ? f[nbits-1-i] : 1'b0;
        for (int i = 0; i < nbits; i++)
            if (msg[i])
                for (int j = 0; j <= 12; j++) msg[i+j] = msg[i+j] ^ gen[12-j];
        for (int k = 0; k < 12; k++) r[11-k] = msg[nbits+k];
        return r;
    endfunction

    function automatic logic [255:0] make_frame(input bit is_data, input logic [7:0] key,
                                                input bit corrupt, input int nbits);
        logic [255:0] f;
        logic [1:0]   h;
        for (int w = 0; w < 8; w++) f[32*w +: 32] = $urandom;
        if (nbits < 256) f = f & ((256'd1 << nbits) - 256'd1);
        h = 2'($urandom_range(0, 2));
        if (h == 2'b01) h = 2'b11;
        f[nbits-1 -: 2] = is_data ? 2'b01 : h;
        f[11:0] = crc_ref(f, nbits) ^ {4'h0, key};
        if (corrupt) f[$urandom_range(0, 11)] ^= 1'b1;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else
            $display("[TB] ok %s = %0h", name, act);
    endtask

    task automatic model_reset();
        m_exp = '0; m_hwm = '0; m_err = 1'b0;
        m_good = '0; m_crc = '0; m_dup = '0; m_abort = '0;
    endtask

    task automatic model_tail(input bit is_data, input bit ok);
        obs_t e;
        e = '0;
        if (!ok) begin
            m_exp = m_hwm - 8'(RB);
            m_err = 1'b1;
            e.rr  = 1'b1;
            e.rid = m_exp;
            m_crc = sat16(m_crc);
        end else begin
            if (8'(m_exp + 8'd1) == m_hwm || m_exp == m_hwm) m_err = 1'b0;
            if (!is_data) e.cg = 1'b1;
            else if (m_exp == m_hwm) begin
                e.fg = 1'b1; m_exp++; m_hwm++; m_good = sat16(m_good);
            end else begin
                e.dup = 1'b1; m_exp++; m_dup = sat16(m_dup);
            end
        end
        e.err = m_err; e.exp = m_exp;
        e.good = m_good; e.crcc = m_crc; e.dupc = m_dup; e.abrt = m_abort;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input bit is_data, input logic [7:0] key, input bit corrupt);
        logic [255:0] f;
        bit           ok;
        f  = make_frame(is_data, key, corrupt, 256);
        ok = !corrupt && (key == m_exp);
        for (int b = 0; b < 4; b++) begin
            bus.rx_up   = 1'b1;
            bus.sof     = (b == 0);
            bus.data_in = f[255-64*b -: 64];
            if (b == 3) model_tail(is_data, ok);
            @(posedge clk); #1;
        end
        bus.rx_up = 1'b0;
        bus.sof   = 1'b0;
    endtask

    // mode 0: stop mid-frame; 1: next frame's sof restarts; 2: rx_up drops for a cycle
    task automatic send_partial(input int k, input int mode);
        for (int b = 0; b < k; b++) begin
            bus.rx_up = 1'b1; bus.sof = (b == 0); bus.data_in = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.sof = 1'b0;
        if (mode == 2) begin
            bus.rx_up = 1'b0;
            @(posedge clk); #1;
        end
        if (mode != 0) m_abort = sat16(m_abort);
    endtask

    task automatic send1(input logic [7:0] key, input bit corrupt, input bit clr);
        logic [255:0] f;
        f = make_frame(1'b1, key, corrupt, 64);
        bus1.rx_up = 1'b1; bus1.sof = 1'b0; bus1.data_in = f[63:0]; bus1.stats_clr = clr;
        @(posedge clk); #1;
        bus1.stats_clr = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_up = 1'b0; bus.sof = 1'b0; bus1.rx_up = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Scoreboard monitor: every verdict pulse pops one expected record.
    initial begin : monitor
        obs_t act, e;
        forever begin
            @(negedge clk);
            if (bus.frame_good | bus.ctrl_good | bus.frame_dup | bus.retrans_req) begin
                act.fg = bus.frame_good; act.cg = bus.ctrl_good; act.dup = bus.frame_dup;
                act.rr = bus.retrans_req; act.rid = bus.retrans_req ? bus.retrans_id : 8'd0;
                act.err = bus.rx_error; act.exp = bus.exp_id; act.good = bus.good_cnt;
                act.crcc = bus.crc_err_cnt; act.dupc = bus.dup_cnt; act.abrt = bus.abort_cnt;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %h expected no verdict", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL sb_verdict: got %h expected %h", act, e);
                    end else
                        $display("[TB] sb ok fg=%0d cg=%0d dup=%0d rr=%0d exp_id=%0d", act.fg,
                                 act.cg, act.dup, act.rr, act.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r;
        bus.rx_up = 0; bus.sof = 0; bus.data_in = '0; bus.stats_clr = 0;
        bus1.rx_up = 0; bus1.sof = 0; bus1.data_in = '0; bus1.stats_clr = 0;
        do_reset();
        check("reset_flags", {bus.frame_good, bus.ctrl_good, bus.frame_dup, bus.rx_error,
              bus.retrans_req, bus.retrans_id, bus.exp_id}, 64'd0);
        check("reset_cnts", {bus.good_cnt, bus.crc_err_cnt, bus.dup_cnt, bus.abort_cnt}, 64'd0);

        for (int i = 0; i < 4; i++) send_frame(1'b1, 8'(i), 1'b0);
        check("four_good", {bus.frame_good, bus.exp_id, bus.good_cnt, bus.rx_error},
              {1'b1, 8'd4, 16'd4, 1'b0});
        for (int i = 4; i < 20; i++) send_frame(1'b1, 8'(i), 1'b0);
        send_frame(1'b1, 8'd20, 1'b1);
        check("crc_fail", {bus.retrans_req, bus.retrans_id, bus.rx_error, bus.exp_id,
              bus.crc_err_cnt}, {1'b1, 8'd4, 1'b1, 8'd4, 16'd1});
        for (int i = 4; i < 20; i++) send_frame(1'b1, 8'(i), 1'b0);
        check("replay_done", {bus.dup_cnt, bus.good_cnt, bus.rx_error, bus.exp_id},
              {16'd16, 16'd20, 1'b0, 8'd20});
        send_frame(1'b1, 8'd20, 1'b0);
        check("after_replay", {bus.frame_good, bus.good_cnt}, {1'b1, 16'd21});
        send_frame(1'b0, 8'd21, 1'b0);
        check("ctrl", {bus.ctrl_good, bus.exp_id, bus.good_cnt, bus.dup_cnt},
              {1'b1, 8'd21, 16'd21, 16'd16});

        send_partial(2, 1);
        send_frame(1'b1, 8'd21, 1'b0);
        check("abort_sof", {bus.frame_good, bus.abort_cnt}, {1'b1, 16'd1});
        send_partial(1, 2);
        check("abort_drop", bus.abort_cnt, 64'd2);

        send_partial(2, 0);
        do_reset();
        check("rst_midframe", {bus.exp_id, bus.good_cnt, bus.abort_cnt, bus.rx_error},
              64'd0);

        for (int i = 0; i < 5; i++) send_frame(1'b1, 8'(i), 1'b0);
        send_frame(1'b1, 8'd5, 1'b1);
        check("wrap_rollback", {bus.retrans_req, bus.retrans_id, bus.exp_id},
              {1'b1, 8'd245, 8'd245});
        for (int i = 0; i < 16; i++) send_frame(1'b1, 8'(245 + i), 1'b0);
        check("wrap_replay", {bus.rx_error, bus.exp_id, bus.dup_cnt}, {1'b0, 8'd5, 16'd16});
        send_frame(1'b1, 8'd5, 1'b0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send_frame(1'b1, m_exp, 1'b0);
            else if (r < 70) send_frame(1'b1, m_exp, 1'b1);
            else if (r < 78) send_frame(1'b1, 8'($urandom), 1'b0);
            else if (r < 86) send_frame(1'b0, m_exp, 1'($urandom_range(0, 1)));
            else if (r < 93) begin
                if ($urandom_range(0, 1) == 1) begin
                    send_partial($urandom_range(1, 3), 1);
                    send_frame(1'b1, m_exp, 1'b0);
                end else
                    send_partial($urandom_range(1, 3), 2);
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    bus.rx_up = 1'($urandom_range(0, 1)); bus.sof = 1'b0;
                    bus.data_in = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
                bus.rx_up = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 check("sb_drained", exp_q.size(), 64'd0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send1(8'(i), 1'b0, 1'b0);
            check("b1_stream", {bus1.frame_good, bus1.exp_id}, {1'b1, 8'(i + 1)});
        end
        check("b1_sat", bus1.good_cnt, 64'd3);
        send1(8'd5, 1'b0, 1'b1);
        check("b1_clr", {bus1.frame_good, bus1.good_cnt}, {1'b1, 2'd0});
        send1(8'd6, 1'b0, 1'b0);
        check("b1_after_clr", {bus1.good_cnt, bus1.exp_id}, {2'd1, 8'd7});
        send1(8'd7, 1'b1, 1'b0);
        check("b1_fail", {bus1.retrans_req, bus1.retrans_id, bus1.rx_error, bus1.crc_err_cnt},
              {1'b1, 8'd247, 1'b1, 2'd1});
        bus1.rx_up = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
